modbus_frame_tx: RTL and testbench

- UART transmitter for 7-byte Modbus-style frames; the transmit side of the existing 56-bit frame receiver path.
- Accepts a 56-bit frame with a single-cycle start strobe and serializes it as 7 bytes, 8N1, LSB first.
- Enforces a Modbus inter-frame idle gap before signalling completion.
- Sits between the frame-building control logic and the board TX pin.

---
 rtl/modbus_frame_tx.sv | 202 ++++++++++++++++++++
 tb/tb_modbus_frame_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_frame_tx.sv
// 8N1 UART transmitter for 7-byte Modbus frames with a trailing inter-frame idle gap.
// Optional MODBUS_CRC_GEN_EN: bytes 5-6 are replaced by a CRC-16/MODBUS generated over bytes 0-4.
module modbus_frame_tx #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned GAP_BITS     = 35
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        TX_Start_Sig,
    input  logic [55:0] TX_Data,
    output logic        TX_Busy_Sig,
    output logic        TX_Done_Sig,
    output logic        TX_Pin_Out
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [2:0]          byte_q, byte_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [55:0]         hold_q, hold_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                baud_last;
    logic [7:0]          cur_byte;
`ifdef MODBUS_CRC_GEN_EN
    logic [15:0]         crc_q, crc_d;
`endif

    assign baud_last = (baud_q == BAUD_LAST);

    always_comb begin
        cur_byte = '0;
        case (byte_q)
            3'd0:    cur_byte = hold_q[7:0];
            3'd1:    cur_byte = hold_q[15:8];
            3'd2:    cur_byte = hold_q[23:16];
            3'd3:    cur_byte = hold_q[31:24];
            3'd4:    cur_byte = hold_q[39:32];
`ifdef MODBUS_CRC_GEN_EN
            3'd5:    cur_byte = crc_q[7:0];
            3'd6:    cur_byte = crc_q[15:8];
`else
            3'd5:    cur_byte = hold_q[47:40];
            3'd6:    cur_byte = hold_q[55:48];
`endif
            default: cur_byte = '0;
        endcase
    end

    // Outputs are registered from the current state, so every line level appears one
    // cycle after the state that produces it; bit periods stay exactly CLKS_PER_BIT.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef MODBUS_CRC_GEN_EN
        crc_d   = crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (TX_Start_Sig) begin
                    hold_d  = TX_Data;
                    byte_d  = '0;
                    bit_d   = '0;
                    baud_d  = '0;
`ifdef MODBUS_CRC_GEN_EN
                    crc_d   = '1;
`endif
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d   = 1'b0;
                busy_d = 1'b1;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = cur_byte;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                tx_d   = shift_q[0];
                busy_d = 1'b1;
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
`ifdef MODBUS_CRC_GEN_EN
                    if (byte_q < 3'd5) begin
                        crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ shift_q[0]) ? 16'hA001 : 16'h0000);
                    end
`endif
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                busy_d = 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_q < 3'd6) begin
                        byte_d  = byte_q + 1'b1;
                        state_d = S_START;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
                if (baud_last) begin
                    baud_d = '0;
                    if (gap_q == GAP_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            gap_q   <= '0;
            hold_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MODBUS_CRC_GEN_EN
            crc_q   <= '1;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MODBUS_CRC_GEN_EN
            crc_q   <= crc_d;
`endif
        end
    end

    assign TX_Pin_Out  = tx_q;
    assign TX_Busy_Sig = busy_q;
    assign TX_Done_Sig = done_q;

endmodule

// File: tb/tb_modbus_frame_tx.sv
// Scoreboard bench for modbus_frame_tx: a UART monitor decodes the line and checks bytes and bit timing.
module tb_modbus_frame_tx;

    localparam int unsigned CPB = 8;
    localparam int unsigned GAP = 4;
    localparam int LATENCY   = 2 + (70 + GAP) * CPB;   // strobe drive to Done sample
    localparam int BUSY_CYC  = (70 + GAP) * CPB;
    localparam int B2B_START = 70 * CPB + GAP * CPB + 2;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        TX_Start_Sig = 1'b0;
    logic [55:0] TX_Data = '0;
    logic        TX_Busy_Sig;
    logic        TX_Done_Sig;
    logic        TX_Pin_Out;

    modbus_frame_tx #(
        .CLKS_PER_BIT(CPB),
        .GAP_BITS    (GAP)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .TX_Start_Sig(TX_Start_Sig),
        .TX_Data     (TX_Data),
        .TX_Busy_Sig (TX_Busy_Sig),
        .TX_Done_Sig (TX_Done_Sig),
        .TX_Pin_Out  (TX_Pin_Out)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         st_q[$];
    logic       mon_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    task automatic push_frame(input logic [55:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int unsigned i = 0; i < 5; i++) begin
            exp_q.push_back(d[8*i +: 8]);
            c = crc_byte(c, d[8*i +: 8]);
        end
`ifdef MODBUS_CRC_GEN_EN
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
`else
        exp_q.push_back(d[47:40]);
        exp_q.push_back(d[55:48]);
`endif
    endtask

    task automatic strobe(input logic [55:0] d, output int s);
        @(negedge CLK);
        TX_Data      = d;
        TX_Start_Sig = 1'b1;
        s            = cyc;
        @(negedge CLK);
        TX_Start_Sig = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc, output int busy_n);
        dcyc   = -1;
        busy_n = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (TX_Busy_Sig) busy_n++;
            if (TX_Done_Sig) begin
                dcyc = cyc;
                break;
            end
        end
        chk("done_seen", dcyc >= 0, 1);
        chk("busy_at_done", TX_Busy_Sig, 0);
    endtask

    // Line monitor: every one of the 10 bit slots must hold a constant level for exactly CPB samples.
    initial begin
        logic       prev;
        logic       v;
        logic       lvl;
        logic       ok;
        logic [9:0] bits;
        int         t0;
        prev = 1'b1;
        lvl  = 1'b1;
        forever begin
            @(negedge CLK);
            if (mon_en && prev && !TX_Pin_Out) begin
                t0 = cyc;
                ok = 1'b1;
                v  = TX_Pin_Out;
                for (int unsigned slot = 0; slot < 10; slot++) begin
                    for (int unsigned c = 0; c < CPB; c++) begin
                        if (slot != 0 || c != 0) @(negedge CLK);
                        v = TX_Pin_Out;
                        if (c == 0) lvl = v;
                        else if (v !== lvl) ok = 1'b0;
                    end
                    bits[slot] = lvl;
                end
                chk("framing", {61'd0, ok, bits[0], bits[9]}, 64'h5);
                st_q.push_back(t0);
                rx_q.push_back(bits[8:1]);
                if (exp_q.size() == 0) chk("extra_byte", exp_q.size(), 1);
                else chk("byte", bits[8:1], exp_q.pop_front());
                prev = v;
            end else begin
                prev = TX_Pin_Out;
            end
        end
    end

    initial begin
        int s, d, d2, bn, nd, nl, bad;
        logic [15:0] c;
        logic [55:0] fc;

        repeat (3) @(negedge CLK);
        chk("rst_pin", TX_Pin_Out, 1);
        chk("rst_busy", TX_Busy_Sig, 0);
        chk("rst_done", TX_Done_Sig, 0);
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_pin", TX_Pin_Out, 1);
        chk("idle_busy", TX_Busy_Sig, 0);
        chk("idle_done", TX_Done_Sig, 0);

        // Abort mid-frame with an asynchronous reset
        strobe(56'h0, s);
        repeat (19) @(negedge CLK);
        chk("abort_pin_low", TX_Pin_Out, 0);
        chk("abort_busy", TX_Busy_Sig, 1);
        #1 RSTn = 1'b0;
        #1;
        chk("abort_pin_async", TX_Pin_Out, 1);
        chk("abort_busy_clr", TX_Busy_Sig, 0);
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        nd = 0;
        nl = 0;
        repeat (700) begin
            @(negedge CLK);
            if (TX_Done_Sig) nd++;
            if (!TX_Pin_Out) nl++;
        end
        chk("abort_no_done", nd, 0);
        chk("abort_line_idle", nl, 0);

        mon_en = 1'b1;

        // Single frame
        push_frame(56'h0A0B0C0D0E0F55);
        strobe(56'h0A0B0C0D0E0F55, s);
        wait_done(2000, d, bn);
        chk("done_latency", d - s, LATENCY);
        chk("busy_cycles", bn, BUSY_CYC);
        @(negedge CLK);
        chk("done_width", TX_Done_Sig, 0);
        chk("frame_bytes", st_q.size(), 7);
        if (st_q.size() == 7) begin
            chk("first_start", st_q[0] - s, 2);
            bad = 0;
            for (int unsigned i = 1; i < 7; i++) if (st_q[i] - st_q[i-1] != 10 * CPB) bad++;
            chk("byte_spacing", bad, 0);
        end
        chk("exp_drained", exp_q.size(), 0);

        // Strobes while busy are ignored, as are TX_Data changes
        st_q.delete();
        push_frame(56'h11223344556677);
        strobe(56'h11223344556677, s);
        for (int unsigned i = 0; i < 11; i++) begin
            repeat (48) @(negedge CLK);
            TX_Data      = {$urandom, $urandom};
            TX_Start_Sig = 1'b1;
            chk("busy_at_restrobe", TX_Busy_Sig, 1);
            @(negedge CLK);
            TX_Start_Sig = 1'b0;
        end
        wait_done(2000, d, bn);
        chk("ignore_latency", d - s, LATENCY);
        repeat (100) @(negedge CLK);
        chk("no_extra_frame", st_q.size(), 7);
        chk("ignore_drained", exp_q.size(), 0);

        st_q.delete();
        push_frame(56'hC3A55A3C0FF000);
        strobe(56'hC3A55A3C0FF000, s);
        wait_done(2000, d, bn);
        chk("second_latency", d - s, LATENCY);
        chk("second_bytes", st_q.size(), 7);

        // Back-to-back with the strobe held high
        repeat (5) @(negedge CLK);
        st_q.delete();
        push_frame(56'h0123456789ABCD);
        push_frame(56'h0123456789ABCD);
        @(negedge CLK);
        TX_Data      = 56'h0123456789ABCD;
        TX_Start_Sig = 1'b1;
        s            = cyc;
        wait_done(2000, d, bn);
        chk("b2b_latency", d - s, LATENCY);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (TX_Busy_Sig) break;
        end
        TX_Start_Sig = 1'b0;
        wait_done(2000, d2, bn);
        chk("b2b_done_period", d2 - d, LATENCY);
        chk("b2b_bytes", st_q.size(), 14);
        if (st_q.size() == 14) begin
            chk("b2b_restart", st_q[7] - d, 2);
            chk("b2b_start_period", st_q[7] - st_q[0], B2B_START);
            chk("b2b_idle_gap", st_q[7] - (st_q[6] + 10 * CPB), GAP * CPB + 2);
        end
        chk("b2b_drained", exp_q.size(), 0);

        // All-zero frame: every data bit low for a full bit period
        repeat (5) @(negedge CLK);
        push_frame(56'h0);
        strobe(56'h0, s);
        wait_done(2000, d, bn);
        chk("zero_busy_cycles", bn, BUSY_CYC);
        chk("zero_latency", d - s, LATENCY);

        // CRC frame
        repeat (5) @(negedge CLK);
        rx_q.delete();
        fc = {16'hFFFF, 40'h0000030601};
        push_frame(fc);
        strobe(fc, s);
        wait_done(2000, d, bn);
        chk("crc_latency", d - s, LATENCY);
        chk("crc_bytes", rx_q.size(), 7);
        if (rx_q.size() == 7) begin
`ifdef MODBUS_CRC_GEN_EN
            c = 16'hFFFF;
            for (int unsigned i = 0; i < 7; i++) c = crc_byte(c, rx_q[i]);
            chk("crc_residue", c, 0);
`else
            chk("crc_passthru", {rx_q[6], rx_q[5]}, 16'hFFFF);
`endif
        end
        chk("crc_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
